// File: rtl/instr_prefetch_queue_pkg.sv
// Shared processor definitions: instruction word size,
// prefetch queue depth and opcode encodings.
package instr_prefetch_queue_pkg;

  localparam int INSTR_W  = 10;
  localparam int IQ_DEPTH = 4;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ALU  = 4'h1,
    OP_LOAD = 4'h2,
    OP_STOR = 4'h3,
    OP_BRCH = 4'h4,
    OP_JUMP = 4'h5
  } opcode_e;

endpackage

// File: rtl/instr_prefetch_queue_wrap_ptr.sv
// Modulo-DEPTH pointer with enable and synchronous clear,
// stepped on the falling clock edge.
import instr_prefetch_queue_pkg::*;

module wrap_ptr #(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_n,
  input  logic          clr,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  // DEPTH is a power of two, so natural overflow is the wrap
  always_comb begin
    ptr_d = ptr_q;
    if (clr)
      ptr_d = '0;
    else if (en)
      ptr_d = ptr_q + PW'(1);
  end

  always_ff @(negedge clk_n) begin
    ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: holds the head instruction until
// Advance, drops enqueues when full and flags that stickily.
import instr_prefetch_queue_pkg::*;

module instr_prefetch_queue #(
  parameter int WIDTH = INSTR_W,
  parameter int DEPTH = IQ_DEPTH
) (
  input  logic                     CLKb,
  input  logic                     Clear,
  input  logic [WIDTH-1:0]         D,
  input  logic                     LoadEN,
  input  logic                     Advance,
  input  logic                     Flush,
  output logic [WIDTH-1:0]         Q,
  output logic                     Empty,
  output logic                     Full,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             ovf_q;
  logic             ovf_d;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          clr_all;
  logic          do_push;
  logic          do_pop;

  assign Empty   = (count_q == '0);
  assign Full    = (count_q == CW'(DEPTH));
  assign clr_all = Clear | Flush;
  assign do_pop  = Advance & ~Empty & ~clr_all;
  // When full, an enqueue only fits if the head retires on the same edge
  assign do_push = LoadEN & (~Full | Advance) & ~clr_all;

  always_comb begin
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    ovf_d   = ovf_q;
    if (clr_all) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (LoadEN && Full && !Advance) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (do_push)
      mem_d[tail] = D;
  end

  always_ff @(negedge CLKb) begin
    count_q <= count_d;
    ovf_q   <= ovf_d;
    mem_q   <= mem_d;
  end

  wrap_ptr #(.DEPTH(DEPTH)) u_head (
    .clk_n (CLKb),
    .clr   (clr_all),
    .en    (do_pop),
    .ptr   (head)
  );

  wrap_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk_n (CLKb),
    .clr   (clr_all),
    .en    (do_push),
    .ptr   (tail)
  );

  assign Q        = Empty ? '0 : mem_q[head];
  assign Count    = count_q;
  assign Overflow = ovf_q;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Directed and random checks of the prefetch queue against
// a queue-based reference model.
module tb_instr_prefetch_queue;

  logic       CLKb;
  logic       Clear;
  logic [9:0] D;
  logic       LoadEN;
  logic       Advance;
  logic       Flush;
  logic [9:0] Q;
  logic       Empty;
  logic       Full;
  logic [2:0] Count;
  logic       Overflow;

  int errors = 0;
  int checks = 0;

  logic [9:0] mq[$];
  logic       movf;

  instr_prefetch_queue #(.WIDTH(10), .DEPTH(4)) dut (
    .CLKb     (CLKb),
    .Clear    (Clear),
    .D        (D),
    .LoadEN   (LoadEN),
    .Advance  (Advance),
    .Flush    (Flush),
    .Q        (Q),
    .Empty    (Empty),
    .Full     (Full),
    .Count    (Count),
    .Overflow (Overflow)
  );

  initial CLKb = 1'b1;
  always #5 CLKb = ~CLKb;

  // reference: an unbounded queue limited to 4 by the rules below
  task automatic model_edge(input logic ld, adv, fl, clr,
                            input logic [9:0] d);
    int n;
    n = mq.size();
    if (clr || fl) begin
      mq.delete();
      movf = 1'b0;
    end else if (ld && n == 4 && !adv) begin
      movf = 1'b1;
    end else begin
      if (adv && n > 0) mq.delete(0);
      if (ld) mq.push_back(d);
    end
  endtask

  task automatic check_all(input string tag);
    logic [9:0] eq;
    logic [2:0] ec;
    eq = (mq.size() > 0) ? mq[0] : 10'h000;
    ec = 3'(mq.size());
    checks++;
    assert (Q === eq) else begin
      errors++;
      $error("FAIL %s Q: got %h expected %h", tag, Q, eq);
    end
    checks++;
    assert (Count === ec) else begin
      errors++;
      $error("FAIL %s Count: got %0d expected %0d", tag, Count, ec);
    end
    checks++;
    assert (Empty === (ec == 0)) else begin
      errors++;
      $error("FAIL %s Empty: got %b expected %b", tag, Empty, ec == 0);
    end
    checks++;
    assert (Full === (ec == 4)) else begin
      errors++;
      $error("FAIL %s Full: got %b expected %b", tag, Full, ec == 4);
    end
    checks++;
    assert (Overflow === movf) else begin
      errors++;
      $error("FAIL %s Overflow: got %b expected %b", tag, Overflow, movf);
    end
  endtask

  task automatic step(input string tag, input logic ld, adv, fl, clr,
                      input logic [9:0] d);
    LoadEN  = ld;
    Advance = adv;
    Flush   = fl;
    Clear   = clr;
    D       = d;
    @(negedge CLKb);
    model_edge(ld, adv, fl, clr, d);
    #1;
    check_all(tag);
  endtask

  task automatic expect_q(input string tag, input logic [9:0] v);
    checks++;
    assert (Q === v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, Q, v);
    end
  endtask

  initial begin
    logic ld, adv, fl, clr;
    LoadEN = 0; Advance = 0; Flush = 0; Clear = 0; D = '0;
    movf = 1'b0;
    @(posedge CLKb);

    step("clear", 0, 0, 0, 1, 10'h0);
    step("clear2", 1, 1, 1, 1, 10'h3AB);

    step("enq1", 1, 0, 0, 0, 10'h011);
    step("enq2", 1, 0, 0, 0, 10'h022);
    step("enq3", 1, 0, 0, 0, 10'h033);
    expect_q("head011", 10'h011);
    for (int i = 0; i < 5; i++) step("hold", 0, 0, 0, 0, 10'h3C3);
    expect_q("hold011", 10'h011);
    step("adv1", 0, 1, 0, 0, 10'h0);
    expect_q("next022", 10'h022);

    step("clr_mid", 1, 1, 0, 1, 10'h155);
    for (int i = 1; i <= 4; i++) step("fill", 1, 0, 0, 0, 10'(32'h100 + i));
    step("ovf", 1, 0, 0, 0, 10'h3FF);
    expect_q("ovf_q101", 10'h101);
    step("full_ld_adv", 1, 1, 0, 0, 10'h0AA);
    expect_q("fla102", 10'h102);
    for (int i = 0; i < 3; i++) step("drain", 0, 1, 0, 0, 10'h0);
    expect_q("tail0AA", 10'h0AA);
    step("drain_last", 0, 1, 0, 0, 10'h0);

    step("wrap_pre", 1, 0, 0, 0, 10'h1E0);
    for (int i = 0; i < 10; i++) begin
      step("wrap_enq", 1, 0, 0, 0, 10'(32'h1F0 + i));
      step("wrap_adv", 0, 1, 0, 0, 10'h0);
      checks++;
      assert (Count <= 3'd4) else begin
        errors++;
        $error("FAIL wrap_cnt: got %0d expected <=4", Count);
      end
    end

    step("f_a", 1, 0, 0, 0, 10'h061);
    step("f_b", 1, 0, 0, 0, 10'h062);
    step("flush", 1, 1, 1, 0, 10'h2EE);
    step("post_flush", 1, 0, 0, 0, 10'h155);
    expect_q("q155", 10'h155);

    step("fl_empty", 0, 0, 1, 0, 10'h0);
    step("adv_empty", 0, 1, 0, 0, 10'h0);
    step("ld_adv_empty", 1, 1, 0, 0, 10'h200);
    expect_q("q200", 10'h200);

    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom % 3) != 0;
      adv = ($urandom % 2) != 0;
      fl  = ($urandom % 25) == 0;
      clr = ($urandom % 50) == 0;
      step("rand", ld, adv, fl, clr, 10'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_prefetch_queue.md
INSTR_PREFETCH_QUEUE -- requirements
Module: instr_prefetch_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 10, instruction word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-003 SHALL have port CLKb  input  1  the single clock; all state updates on its falling edge.
REQ-004 SHALL have port Clear  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port D  input  WIDTH  instruction word to enqueue.
REQ-006 SHALL have port LoadEN  input  1  enqueue request, sampled on the falling edge.
REQ-007 SHALL have port Advance  input  1  retire the current instruction and present the next.
REQ-008 SHALL have port Flush  input  1  discard all queued instructions, e.g. on a branch.
REQ-009 SHALL have port Q  output  WIDTH  current instruction, the head entry.
REQ-010 SHALL have port Empty  output  1  queue holds no entries.
REQ-011 SHALL have port Full  output  1  queue holds DEPTH entries.
REQ-012 SHALL have port Count  output  $clog2(DEPTH)+1  number of valid entries.
REQ-013 SHALL have port Overflow  output  1  sticky flag: an enqueue was dropped.

Function
REQ-014 SHALL update all storage, pointers, Count and Overflow only on the falling edge of CLKb.
REQ-015 SHALL drive Q combinationally from the head entry when Empty=0, and drive all-zeros when Empty=1.
REQ-016 SHALL hold Q stable across any number of cycles while Advance=0, so the instruction is kept for multi-cycle execution.
REQ-017 SHALL derive Empty as (Count==0) and Full as (Count==DEPTH), both combinationally.
REQ-018 SHALL write D to the tail and increment Count when LoadEN=1 and Full=0; the word appears on Q one edge later if the queue was empty.
REQ-019 SHALL advance the head and decrement Count when Advance=1 and Empty=0; the next entry appears on Q immediately after the edge.
REQ-020 SHALL perform both operations when LoadEN=1 and Advance=1 with 0<Count<DEPTH, leaving Count unchanged.
REQ-021 SHALL, when Full=1 and LoadEN=1 and Advance=1, retire the head and enqueue D, leaving Count=DEPTH and Overflow unchanged.
REQ-022 SHALL, when Full=1 and LoadEN=1 and Advance=0, drop D, leave the queue unchanged, and set Overflow=1.
REQ-023 SHALL ignore Advance when Empty=1; with LoadEN=1 on the same edge the enqueue alone occurs (Count 0->1).
REQ-024 SHALL wrap head and tail pointers modulo DEPTH with no gap or duplicate entry at the wrap.
REQ-025 SHALL, when Flush=1, set Count=0, set head=tail=0, and clear Overflow, taking priority over LoadEN and Advance on the same edge, with D discarded.
REQ-026 SHALL keep Overflow at 1 until Clear or Flush.

Reset
REQ-027 SHALL, on a falling edge with Clear=1, set Count=0, head=tail=0 and Overflow=0, giving Q=0, Empty=1 and Full=0 after that edge.
REQ-028 SHALL give Clear priority over Flush, LoadEN and Advance.
REQ-029 SHALL, when Clear is asserted mid-operation, discard all entries with no partial enqueue.
REQ-030 SHALL NOT reset storage array contents; they are unobservable while Empty=1.

Structure
REQ-031 SHALL take the INSTR_W=10 and IQ_DEPTH=4 defaults from the shared processor package, alongside the opcode typedefs.
REQ-032 SHALL instantiate one sub-module, wrap_ptr: a modulo-DEPTH pointer with enable and synchronous clear, used for both head and tail.
REQ-033 SHALL contain no latches and no logic sensitive to the rising edge of CLKb.

Verification (WIDTH=10, DEPTH=4)
REQ-034 Bench SHALL cover: Clear -> Q=0, Empty=1, Count=0, Overflow=0.
REQ-035 Bench SHALL cover: enqueue 0x011, 0x022, 0x033 -> Q=0x011, Count=3; hold Advance=0 for 5 cycles -> Q stays 0x011; Advance x1 -> Q=0x022.
REQ-036 Bench SHALL cover: fill with 0x101..0x104 -> Full=1; LoadEN with D=0x3FF, Advance=0 -> Overflow=1, Count=4, Q=0x101; simultaneous LoadEN with D=0x0AA and Advance=1 -> Q=0x102, Count=4, tail entry 0x0AA.
REQ-037 Bench SHALL cover: 10 interleaved enqueue/advance pairs crossing the pointer wrap -> Q follows strict FIFO order, Count never exceeds 4.
REQ-038 Bench SHALL cover: Count=3 with Flush, LoadEN and Advance all 1 -> Count=0, Q=0, Overflow=0; a next enqueue of 0x155 -> Q=0x155.
REQ-039 Bench SHALL cover: Advance on empty -> no change; LoadEN+Advance on empty with D=0x200 -> Count=1, Q=0x200.
